// File: rtl/qam16_integrate_slicer_pkg.sv
// Shared QAM16 level constants and types for the integrate/slice block and
// the de-symbol mapper downstream.
package qam16_integrate_slicer_pkg;

    typedef logic signed [3:0] qam_lvl_t;

    localparam qam_lvl_t QAM_LVL_M3 = 4'sb1101;
    localparam qam_lvl_t QAM_LVL_M1 = 4'sb1111;
    localparam qam_lvl_t QAM_LVL_P1 = 4'sb0001;
    localparam qam_lvl_t QAM_LVL_P3 = 4'sb0011;

endpackage

// File: rtl/qam16_slice4.sv
// Combinational 4-level slicer: compares a symbol sum against +/-thr_i.
// Ties resolve upward except at -thr_i, which stays at -1.
module qam16_slice4
    import qam16_integrate_slicer_pkg::*;
#(
    parameter int W = 10
) (
    input  logic signed [W-1:0] s_i,
    input  logic signed [W-1:0] thr_i,
    output qam_lvl_t            lvl_o
);

    logic signed [W-1:0] neg_thr;

    always_comb begin
        neg_thr = -thr_i;
        if (s_i >= thr_i)       lvl_o = QAM_LVL_P3;
        else if (!s_i[W-1])     lvl_o = QAM_LVL_P1;
        else if (s_i >= neg_thr) lvl_o = QAM_LVL_M1;
        else                    lvl_o = QAM_LVL_M3;
    end

endmodule

// File: rtl/qam16_integrate_slicer.sv
// Integrate-and-dump downsampler with per-rail 4-level slicing for QAM16 RX.
// Define SLICER_ERR_EN to add registered slicer-error outputs err_i/err_q.
module qam16_integrate_slicer
    import qam16_integrate_slicer_pkg::*;
#(
    parameter  int W_IN       = 8,
    parameter  int SPS        = 4,
    parameter  int LEVEL_UNIT = 16,
    localparam int W_ACC      = W_IN + $clog2(SPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [W_IN-1:0]  i_in,
    input  logic signed [W_IN-1:0]  q_in,
    input  logic                    sym_sync,
    output logic signed [3:0]       i_down,
    output logic signed [3:0]       q_down,
    output logic                    sym_valid
`ifdef SLICER_ERR_EN
    ,
    output logic signed [W_ACC:0]   err_i,
    output logic signed [W_ACC:0]   err_q
`endif
);

    localparam int                    PH_W    = $clog2(SPS);
    localparam logic [PH_W-1:0]       PH_LAST = PH_W'(SPS - 1);
    localparam logic signed [W_ACC-1:0] THR   = W_ACC'(2 * LEVEL_UNIT * SPS);

    logic [PH_W-1:0]          phase_q, phase_d;
    logic signed [W_ACC-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [W_ACC-1:0]  smp_i, smp_q, sum_i, sum_q;
    qam_lvl_t                 lvl_i, lvl_q;
    qam_lvl_t                 down_i_q, down_i_d, down_q_q, down_q_d;
    logic                     sv_q, sv_d;
    logic                     dump;

    qam16_slice4 #(.W(W_ACC)) u_slice_i (.s_i(sum_i), .thr_i(THR), .lvl_o(lvl_i));
    qam16_slice4 #(.W(W_ACC)) u_slice_q (.s_i(sum_q), .thr_i(THR), .lvl_o(lvl_q));

    always_comb begin
        smp_i    = W_ACC'(i_in);
        smp_q    = W_ACC'(q_in);
        sum_i    = acc_i_q + smp_i;
        sum_q    = acc_q_q + smp_q;
        phase_d  = phase_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        down_i_d = down_i_q;
        down_q_d = down_q_q;
        sv_d     = 1'b0;
        dump     = 1'b0;
        if (in_valid) begin
            // A sync sample restarts the symbol even on the would-be dump phase.
            if (sym_sync || phase_q == '0) begin
                phase_d = PH_W'(1);
                acc_i_d = smp_i;
                acc_q_d = smp_q;
            end else if (phase_q == PH_LAST) begin
                phase_d  = '0;
                dump     = 1'b1;
                sv_d     = 1'b1;
                down_i_d = lvl_i;
                down_q_d = lvl_q;
            end else begin
                phase_d = phase_q + PH_W'(1);
                acc_i_d = sum_i;
                acc_q_d = sum_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            down_i_q <= QAM_LVL_M3;
            down_q_q <= QAM_LVL_M3;
            sv_q     <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            down_i_q <= down_i_d;
            down_q_q <= down_q_d;
            sv_q     <= sv_d;
        end
    end

    assign i_down    = down_i_q;
    assign q_down    = down_q_q;
    assign sym_valid = sv_q;

`ifdef SLICER_ERR_EN
    localparam logic signed [W_ACC:0] UNIT = (W_ACC+1)'(LEVEL_UNIT * SPS);

    logic signed [W_ACC:0] err_i_q, err_i_d, err_q_q, err_q_d;

    function automatic logic signed [W_ACC:0] lvl_scale(input qam_lvl_t l);
        logic signed [W_ACC:0] l_ext;
        l_ext = (W_ACC+1)'(l);
        return l_ext * UNIT;
    endfunction

    always_comb begin
        err_i_d = err_i_q;
        err_q_d = err_q_q;
        if (dump) begin
            err_i_d = (W_ACC+1)'(sum_i) - lvl_scale(lvl_i);
            err_q_d = (W_ACC+1)'(sum_q) - lvl_scale(lvl_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_i_q <= '0;
            err_q_q <= '0;
        end else begin
            err_i_q <= err_i_d;
            err_q_q <= err_q_d;
        end
    end

    assign err_i = err_i_q;
    assign err_q = err_q_q;
`endif

endmodule
